fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage (IF) directly upstream of decode_stage.
- Owns the PC and next-PC, and issues SRAM-like instruction requests (req/addr_ok handshake).
- Presents one fetch slot (valid/pc/cancelled/exception) to decode. Decode consumes inst_data_ok itself.
- Handles branch redirect, exception/ERET flush, and address-error (AdEL) detection.

Parameters:
- RESET_PC, 32'hbfc00000, first PC fetched after reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- inst_req  out  1  instruction request
- inst_addr  out  32  request address (= next_pc)
- inst_addr_ok  in  1  request accepted this cycle
- fd_advance  in  1  decode done_o && decode ready_i; current slot consumed
- redirect_i  in  1  branch/jump resolved; target applies after current slot (delay slot already in flight)
- redirect_pc  in  32  branch/jump target
- flush_i  in  1  exception/ERET flush
- flush_pc  in  32  handler/EPC address
- valid_o  out  1  slot present (to decode valid_i)
- pc_o  out  32  slot PC
- cancelled_o  out  1  slot flushed; decode discards it but still absorbs its inst_data_ok
- exc_o  out  1  slot carries exception
- exc_miss_o  out  1  TLB-refill flag; constant 0 in this block
- exccode_o  out  5  exception code
- perfcnt_req_wait  out  32  cycles with inst_req && !inst_addr_ok

Behaviour:
- States:
  - S_REQ: request outstanding, no slot.
  - S_SLOT: slot held for decode.
- Reset (async):
  - state=S_REQ, next_pc=RESET_PC.
  - valid_o=0, pc_o=0, cancelled_o=0, exc_o=0, exc_miss_o=0, exccode_o=0, perfcnt_req_wait=0.
- inst_addr = next_pc, always.
- AdEL check (aligned = next_pc[1:0]==0):
  - inst_req = aligned && (state==S_REQ || (state==S_SLOT && fd_advance)).
  - A misaligned next_pc never raises inst_req.
- Slot load:
  - Condition: (inst_req && inst_addr_ok) or (!aligned && state allows issue).
  - Next cycle: state=S_SLOT, valid_o=1, pc_o=next_pc, cancelled_o=flush_i.
  - Misaligned load: exc_o=1, exccode_o=5'h04. Aligned load: exc_o=0, exccode_o=0.
  - next_pc <= next_pc+4, unless overridden by redirect/flush.
- S_SLOT && fd_advance without a new load: state=S_REQ, valid_o=0, cancelled_o=0.
- S_SLOT, no advance: all slot outputs hold.
- Back-to-back throughput: if fd_advance and inst_addr_ok arrive in the same cycle, the next slot loads directly (1 instr/cycle).
- next_pc update priority, highest first:
  - flush_i: next_pc <= flush_pc. If state==S_SLOT without a same-cycle load, cancelled_o <= 1.
  - redirect_i: next_pc <= redirect_pc.
  - slot load: next_pc <= next_pc+4.
- Flush in S_REQ with no addr_ok: next_pc is replaced, inst_addr changes next cycle, no cancelled slot is created.
- Flush with addr_ok in the same cycle: the new slot loads with cancelled_o=1.
- Redirect while in S_REQ (delay slot not yet accepted): target is stored. It takes effect only after the delay-slot request is accepted, so a separate pending_redirect flag + target register is required.
  - pending_redirect is cleared by flush.
- Flush and redirect in the same cycle: flush wins; the redirect is dropped.
- cancelled_o and exc_o are never cleared mid-slot except by a flush, which sets cancelled_o.
- perfcnt_req_wait: +1 per cycle of inst_req && !inst_addr_ok; wraps at 2^32.
- Reset mid-request: state returns to S_REQ at RESET_PC. No outstanding-request bookkeeping survives.

Test Plan:
- Reset release, inst_addr_ok tied 1, fd_advance tied 1 -> inst_addr bfc00000, bfc00004, bfc00008 on consecutive cycles; valid_o=1 from the 2nd cycle; pc_o trails inst_addr by one cycle.
- inst_addr_ok held low 3 cycles -> inst_req stays 1, inst_addr stable, perfcnt_req_wait=3, valid_o=0.
- Slot pc=bfc00010, redirect_i to 80001000 while delay slot bfc00014 still in S_REQ -> next accepted addresses bfc00014 then 80001000.
- Slot held (fd_advance=0) at pc=bfc00020, flush_i with flush_pc=bfc00380 -> cancelled_o=1 next cycle, pc_o unchanged; after fd_advance, next inst_addr=bfc00380 with cancelled_o=0.
- flush_pc=bfc00382 -> no inst_req issued; slot valid_o=1, exc_o=1, exccode_o=04, pc_o=bfc00382.
- Assert reset while inst_req=1 mid-wait -> all outputs zero immediately; after release, inst_addr=bfc00000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PC/next-PC, issues req/addr_ok requests, holds one slot for decode.
// Slot appears the cycle after acceptance; a held slot (no fd_advance) blocks new requests.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        fd_advance,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc,
    input  logic        flush_i,
    input  logic [31:0] flush_pc,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic        cancelled_o,
    output logic        exc_o,
    output logic        exc_miss_o,
    output logic [4:0]  exccode_o,
    output logic [31:0] perfcnt_req_wait
);

    localparam logic [0:0] S_REQ  = 1'b0;
    localparam logic [0:0] S_SLOT = 1'b1;

    logic [0:0]  state;
    logic [31:0] next_pc;
    logic        pend_redirect;
    logic [31:0] pend_pc;
    logic        aligned;
    logic        can_issue;
    logic        load;

    assign aligned    = (next_pc[1:0] == 2'b00);
    assign can_issue  = (state == S_REQ) || ((state == S_SLOT) && fd_advance);
    assign inst_req   = aligned && can_issue;
    assign inst_addr  = next_pc;
    // A misaligned PC never goes to memory; it becomes an AdEL slot directly.
    assign load       = (inst_req && inst_addr_ok) || (!aligned && can_issue);
    assign exc_miss_o = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_REQ;
            next_pc          <= RESET_PC;
            pend_redirect    <= 1'b0;
            pend_pc          <= 32'h0;
            valid_o          <= 1'b0;
            pc_o             <= 32'h0;
            cancelled_o      <= 1'b0;
            exc_o            <= 1'b0;
            exccode_o        <= 5'h0;
            perfcnt_req_wait <= 32'h0;
        end else begin
            if (load) begin
                state       <= S_SLOT;
                valid_o     <= 1'b1;
                pc_o        <= next_pc;
                cancelled_o <= flush_i;
                exc_o       <= !aligned;
                exccode_o   <= aligned ? 5'h00 : 5'h04;
            end else if ((state == S_SLOT) && fd_advance) begin
                state       <= S_REQ;
                valid_o     <= 1'b0;
                cancelled_o <= 1'b0;
            end else if ((state == S_SLOT) && flush_i) begin
                cancelled_o <= 1'b1;
            end

            // The redirect target follows the delay slot, so it is parked until that slot is accepted.
            if (flush_i) begin
                next_pc       <= flush_pc;
                pend_redirect <= 1'b0;
            end else if (redirect_i) begin
                if (load) begin
                    next_pc       <= redirect_pc;
                    pend_redirect <= 1'b0;
                end else begin
                    pend_redirect <= 1'b1;
                    pend_pc       <= redirect_pc;
                end
            end else if (load) begin
                if (pend_redirect) begin
                    next_pc       <= pend_pc;
                    pend_redirect <= 1'b0;
                end else begin
                    next_pc <= next_pc + 32'd4;
                end
            end

            if (inst_req && !inst_addr_ok)
                perfcnt_req_wait <= perfcnt_req_wait + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage; inputs change and outputs are sampled 1ns after posedge.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        fd_advance;
    logic        redirect_i;
    logic [31:0] redirect_pc;
    logic        flush_i;
    logic [31:0] flush_pc;
    logic        valid_o;
    logic [31:0] pc_o;
    logic        cancelled_o;
    logic        exc_o;
    logic        exc_miss_o;
    logic [4:0]  exccode_o;
    logic [31:0] perfcnt_req_wait;

    int n_vec;
    int n_bad;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .inst_req         (inst_req),
        .inst_addr        (inst_addr),
        .inst_addr_ok     (inst_addr_ok),
        .fd_advance       (fd_advance),
        .redirect_i       (redirect_i),
        .redirect_pc      (redirect_pc),
        .flush_i          (flush_i),
        .flush_pc         (flush_pc),
        .valid_o          (valid_o),
        .pc_o             (pc_o),
        .cancelled_o      (cancelled_o),
        .exc_o            (exc_o),
        .exc_miss_o       (exc_miss_o),
        .exccode_o        (exccode_o),
        .perfcnt_req_wait (perfcnt_req_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc,
                            input logic c, input logic [31:0] addr);
        chk({tag, ".valid"}, {31'h0, valid_o}, {31'h0, v});
        chk({tag, ".pc"}, pc_o, pc);
        chk({tag, ".cancelled"}, {31'h0, cancelled_o}, {31'h0, c});
        chk({tag, ".addr"}, inst_addr, addr);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        inst_addr_ok = 1'b0;
        fd_advance = 1'b0;
        redirect_i = 1'b0;
        redirect_pc = 32'h0;
        flush_i = 1'b0;
        flush_pc = 32'h0;
        step();
        step();

        // Reset state
        chk_slot("rst", 1'b0, 32'h0, 1'b0, 32'hbfc00000);
        chk("rst.exc", {31'h0, exc_o}, 32'h0);
        chk("rst.exccode", {27'h0, exccode_o}, 32'h0);
        chk("rst.excmiss", {31'h0, exc_miss_o}, 32'h0);
        chk("rst.perf", perfcnt_req_wait, 32'h0);

        // Streaming at one instruction per cycle
        reset = 1'b0;
        inst_addr_ok = 1'b1;
        fd_advance = 1'b1;
        #1;
        chk("s0.req", {31'h0, inst_req}, 32'h1);
        chk_slot("s0", 1'b0, 32'h0, 1'b0, 32'hbfc00000);
        step();
        chk_slot("s1", 1'b1, 32'hbfc00000, 1'b0, 32'hbfc00004);
        step();
        chk_slot("s2", 1'b1, 32'hbfc00004, 1'b0, 32'hbfc00008);
        step();
        chk_slot("s3", 1'b1, 32'hbfc00008, 1'b0, 32'hbfc0000c);

        // addr_ok withheld for three cycles
        inst_addr_ok = 1'b0;
        step();
        step();
        step();
        chk("wait.perf", perfcnt_req_wait, 32'd3);
        chk("wait.req", {31'h0, inst_req}, 32'h1);
        chk_slot("wait", 1'b0, 32'hbfc00008, 1'b0, 32'hbfc0000c);

        // Held slot blocks the next request
        inst_addr_ok = 1'b1;
        fd_advance = 1'b0;
        step();
        chk_slot("hold", 1'b1, 32'hbfc0000c, 1'b0, 32'hbfc00010);
        chk("hold.req", {31'h0, inst_req}, 32'h0);
        fd_advance = 1'b1;
        step();
        chk_slot("br", 1'b1, 32'hbfc00010, 1'b0, 32'hbfc00014);

        // Redirect before the delay slot is accepted
        inst_addr_ok = 1'b0;
        redirect_i = 1'b1;
        redirect_pc = 32'h80001000;
        step();
        redirect_i = 1'b0;
        chk_slot("rd.wait", 1'b0, 32'hbfc00010, 1'b0, 32'hbfc00014);
        chk("rd.perf", perfcnt_req_wait, 32'd4);
        inst_addr_ok = 1'b1;
        step();
        chk_slot("rd.ds", 1'b1, 32'hbfc00014, 1'b0, 32'h80001000);
        step();
        chk_slot("rd.tgt", 1'b1, 32'h80001000, 1'b0, 32'h80001004);

        // Redirect coinciding with delay-slot acceptance
        redirect_i = 1'b1;
        redirect_pc = 32'hbfc00020;
        step();
        redirect_i = 1'b0;
        chk_slot("rd2.ds", 1'b1, 32'h80001004, 1'b0, 32'hbfc00020);
        step();
        chk_slot("rd2.tgt", 1'b1, 32'hbfc00020, 1'b0, 32'hbfc00024);

        // Flush against a held slot
        fd_advance = 1'b0;
        flush_i = 1'b1;
        flush_pc = 32'hbfc00380;
        step();
        flush_i = 1'b0;
        chk_slot("fl.held", 1'b1, 32'hbfc00020, 1'b1, 32'hbfc00380);
        chk("fl.req", {31'h0, inst_req}, 32'h0);
        fd_advance = 1'b1;
        step();
        chk_slot("fl.new", 1'b1, 32'hbfc00380, 1'b0, 32'hbfc00384);

        // Flush with same-cycle acceptance, to a misaligned handler
        flush_i = 1'b1;
        flush_pc = 32'hbfc00382;
        step();
        flush_i = 1'b0;
        chk_slot("fl2", 1'b1, 32'hbfc00384, 1'b1, 32'hbfc00382);
        chk("fl2.req", {31'h0, inst_req}, 32'h0);
        step();
        chk_slot("adel", 1'b1, 32'hbfc00382, 1'b0, 32'hbfc00386);
        chk("adel.exc", {31'h0, exc_o}, 32'h1);
        chk("adel.code", {27'h0, exccode_o}, 32'h4);
        chk("adel.req", {31'h0, inst_req}, 32'h0);
        chk("adel.perf", perfcnt_req_wait, 32'd4);

        // Reset in the middle of a stalled request
        flush_i = 1'b1;
        flush_pc = 32'hbfc00400;
        step();
        flush_i = 1'b0;
        inst_addr_ok = 1'b0;
        step();
        chk("mid.req", {31'h0, inst_req}, 32'h1);
        chk("mid.addr", inst_addr, 32'hbfc00400);
        chk("mid.perf", perfcnt_req_wait, 32'd5);
        reset = 1'b1;
        #1;
        chk_slot("arst", 1'b0, 32'h0, 1'b0, 32'hbfc00000);
        chk("arst.exc", {31'h0, exc_o}, 32'h0);
        chk("arst.perf", perfcnt_req_wait, 32'h0);
        step();
        reset = 1'b0;
        step();
        chk("post.addr", inst_addr, 32'hbfc00000);
        chk("post.req", {31'h0, inst_req}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
